// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one serial writer between two byte-stream requesters.
// Requester 0 carries mouse reports, requester 1 carries debug/status bytes.
// Grants are packet-atomic (held until a byte flagged last is sent); ties
// are settled round-robin. Each byte is sequenced as write strobe, one
// tbr-mask cycle, then a wait for tbr. A gap timeout reclaims the writer
// from a requester that stalls mid-packet.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req0/data0/last0, ack0   requester 0 byte handshake (ack0 = consumed)
//   req1/data1/last1, ack1   requester 1 byte handshake (ack1 = consumed)
//   tbr                      writer transmit buffer ready
//   write, data_out          1-cycle strobe and byte to the writer
//   grant                    one-hot owner, 00 when idle
//   abort                    1-cycle pulse when the gap timeout releases a grant
module tx_arbiter #(
  parameter int unsigned GAP_LIMIT = 255,
  parameter int unsigned GAP_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack1,
  input  logic       tbr,
  output logic       write,
  output logic [7:0] data_out,
  output logic [1:0] grant,
  output logic       abort
);

  typedef enum logic [1:0] {IDLE, SEND, HOLD, DRAIN} state_t;

  state_t             state, state_d;
  logic [1:0]         grant_d;
  logic               write_d, ack0_d, ack1_d, abort_d;
  logic [7:0]         data_d;
  logic               last_q, last_d;
  logic [GAP_W-1:0]   gap, gap_d;
  // 1 when requester 1 owned the most recent packet, so requester 0 wins
  // the next tie; reset value makes requester 0 preferred first.
  logic               served1, served1_d;

  logic               own_req, own_last;
  logic [7:0]         own_data;

  assign own_req  = grant[1] ? req1  : req0;
  assign own_data = grant[1] ? data1 : data0;
  assign own_last = grant[1] ? last1 : last0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      write    <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      abort    <= 1'b0;
      data_out <= '0;
      last_q   <= 1'b0;
      gap      <= '0;
      served1  <= 1'b1;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      write    <= write_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      abort    <= abort_d;
      data_out <= data_d;
      last_q   <= last_d;
      gap      <= gap_d;
      served1  <= served1_d;
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    write_d   = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    abort_d   = 1'b0;
    data_d    = data_out;
    last_d    = last_q;
    gap_d     = gap;
    served1_d = served1;
    unique case (state)
      IDLE: begin
        if (req0 && (!req1 || served1)) begin
          grant_d = 2'b01;
          gap_d   = '0;
          state_d = SEND;
        end else if (req1) begin
          grant_d = 2'b10;
          gap_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A busy writer (tbr low) freezes the gap count even while the
        // owner is idle, so a slow writer can never trigger an abort.
        if (tbr) begin
          if (own_req) begin
            write_d = 1'b1;
            ack0_d  = grant[0];
            ack1_d  = grant[1];
            data_d  = own_data;
            last_d  = own_last;
            gap_d   = '0;
            state_d = HOLD;
          end else if (gap == GAP_W'(GAP_LIMIT - 1)) begin
            abort_d   = 1'b1;
            grant_d   = '0;
            served1_d = grant[1];
            gap_d     = '0;
            state_d   = IDLE;
          end else begin
            gap_d = gap + 1'b1;
          end
        end
      end
      HOLD: state_d = DRAIN;
      DRAIN: begin
        if (tbr) begin
          if (last_q) begin
            grant_d   = '0;
            served1_d = grant[1];
            state_d   = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: self-checking bench for tx_arbiter (GAP_LIMIT=4).
// A vector table covers reset and a packet hand-over, hand-written
// sequences cover round-robin, tbr stall, gap abort and mid-packet reset,
// and a randomized phase checks the writer stream against per-requester
// byte queues and packet-level ordering rules.
module tb_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, last0, req1, last1, tbr;
  logic [7:0] data0, data1;
  logic       ack0, ack1, write, abort;
  logic [7:0] data_out;
  logic [1:0] grant;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tx_arbiter #(.GAP_LIMIT(4), .GAP_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .tbr(tbr), .write(write), .data_out(data_out),
    .grant(grant), .abort(abort)
  );

  // Inputs packed as {req0,last0,req1,last1,tbr}; expected outputs packed
  // as {write,ack0,ack1,abort,grant[1:0],data_out[7:0]}.
  typedef struct {
    logic [4:0]  ctl;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [13:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] obs();
    return {write, ack0, ack1, abort, grant, data_out};
  endfunction

  function automatic vec_t mk(input logic [4:0] ctl, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [13:0] exp);
    vec_t v;
    v.ctl = ctl; v.d0 = d0; v.d1 = d1; v.exp = exp;
    return v;
  endfunction

  task automatic clear_inputs();
    req0 = 1'b0; data0 = '0; last0 = 1'b0;
    req1 = 1'b0; data1 = '0; last1 = 1'b0;
    tbr  = 1'b1;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("reset_outputs_zero", 32'(obs()), 0);
    step();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  vec_t       vecs[16];
  logic [1:0] eg[3];
  logic [7:0] ed[3];
  logic [1:0] gseq[3];
  logic [7:0] dseq[3];
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  initial begin
    int nw;
    logic quiet;

    // Test 1 and 2 as a vector table: reset with req0 held, A1..A3 packet
    // from requester 0 while requester 1 waits, then requester 1's byte.
    vecs[0]  = mk(5'b10111, 8'hA1, 8'hB1, {4'b0000, 2'b01, 8'h00});
    vecs[1]  = mk(5'b10111, 8'hA1, 8'hB1, {4'b1100, 2'b01, 8'hA1});
    vecs[2]  = mk(5'b10110, 8'hA2, 8'hB1, {4'b0000, 2'b01, 8'hA1});
    vecs[3]  = mk(5'b10110, 8'hA2, 8'hB1, {4'b0000, 2'b01, 8'hA1});
    vecs[4]  = mk(5'b10111, 8'hA2, 8'hB1, {4'b0000, 2'b01, 8'hA1});
    vecs[5]  = mk(5'b10111, 8'hA2, 8'hB1, {4'b1100, 2'b01, 8'hA2});
    vecs[6]  = mk(5'b11111, 8'hA3, 8'hB1, {4'b0000, 2'b01, 8'hA2});
    vecs[7]  = mk(5'b11111, 8'hA3, 8'hB1, {4'b0000, 2'b01, 8'hA2});
    vecs[8]  = mk(5'b11111, 8'hA3, 8'hB1, {4'b1100, 2'b01, 8'hA3});
    vecs[9]  = mk(5'b01111, 8'hA3, 8'hB1, {4'b0000, 2'b01, 8'hA3});
    vecs[10] = mk(5'b01111, 8'hA3, 8'hB1, {4'b0000, 2'b00, 8'hA3});
    vecs[11] = mk(5'b01111, 8'hA3, 8'hB1, {4'b0000, 2'b10, 8'hA3});
    vecs[12] = mk(5'b01111, 8'hA3, 8'hB1, {4'b1010, 2'b10, 8'hB1});
    vecs[13] = mk(5'b01011, 8'hA3, 8'hB1, {4'b0000, 2'b10, 8'hB1});
    vecs[14] = mk(5'b01011, 8'hA3, 8'hB1, {4'b0000, 2'b00, 8'hB1});
    vecs[15] = mk(5'b01011, 8'hA3, 8'hB1, {4'b0000, 2'b00, 8'hB1});

    rst = 1'b0;
    clear_inputs();
    {req0, last0, req1, last1, tbr} = vecs[0].ctl;
    data0 = vecs[0].d0;
    data1 = vecs[0].d1;
    repeat (3) step();
    check("reset_state", 32'(obs()), 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      {req0, last0, req1, last1, tbr} = vecs[i].ctl;
      data0 = vecs[i].d0;
      data1 = vecs[i].d1;
      step();
      check($sformatf("vec_%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // Test 3: both requesters rise together and stay high with 1-byte
    // packets; grants must alternate starting with requester 0.
    clear_inputs();
    reset_pulse();
    req0 = 1'b1; data0 = 8'hC0; last0 = 1'b1;
    req1 = 1'b1; data1 = 8'hD0; last1 = 1'b1;
    eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01;
    ed[0] = 8'hC0; ed[1] = 8'hD0; ed[2] = 8'hC0;
    nw = 0;
    for (int c = 0; c < 60 && nw < 3; c++) begin
      step();
      if (write) begin
        gseq[nw] = grant;
        dseq[nw] = data_out;
        nw++;
      end
    end
    check("rr_write_count", 32'(nw), 3);
    for (int i = 0; i < nw; i++)
      check($sformatf("rr_write_%0d", i), 32'({gseq[i], dseq[i]}), 32'({eg[i], ed[i]}));

    // Test 4: tbr held low for 50 cycles in SEND, then released.
    clear_inputs();
    reset_pulse();
    req0 = 1'b1; data0 = 8'hE0; last0 = 1'b1; tbr = 1'b0;
    step();
    check("t4_grant", 32'(grant), 32'(2'b01));
    quiet = 1'b0;
    repeat (50) begin
      step();
      quiet |= write | abort;
    end
    check("t4_stall_quiet", 32'(quiet), 0);
    tbr = 1'b1;
    step();
    check("t4_write_after_tbr", 32'({write, ack0, data_out}), 32'({2'b11, 8'hE0}));
    req0 = 1'b0;
    repeat (4) step();

    // Test 5: requester 0 stalls after its first byte; gap abort after
    // four SEND cycles, then pending requester 1 is served.
    clear_inputs();
    reset_pulse();
    req0 = 1'b1; data0 = 8'hF1; last0 = 1'b0;
    req1 = 1'b1; data1 = 8'hF2; last1 = 1'b1;
    step();
    check("t5_grant0", 32'(grant), 32'(2'b01));
    step();
    check("t5_first_write", 32'({write, data_out}), 32'({1'b1, 8'hF1}));
    req0 = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5_no_abort_%0d", i), 32'({abort, grant}), 32'({1'b0, 2'b01}));
    end
    step();
    check("t5_abort", 32'({abort, grant}), 32'({1'b1, 2'b00}));
    step();
    check("t5_regrant", 32'({abort, grant}), 32'({1'b0, 2'b10}));
    step();
    check("t5_req1_write", 32'({write, ack0, ack1, data_out}), 32'({3'b101, 8'hF2}));
    req1 = 1'b0;
    repeat (4) step();

    // Test 6: asynchronous reset while waiting in DRAIN.
    clear_inputs();
    reset_pulse();
    req0 = 1'b1; data0 = 8'h61; last0 = 1'b0;
    step();
    step();
    check("t6_write", 32'({write, data_out}), 32'({1'b1, 8'h61}));
    tbr = 1'b0;
    step();
    step();
    check("t6_in_drain", 32'({write, grant, data_out}), 32'({3'b001, 8'h61}));
    #2 rst = 1'b0;
    #1 check("t6_async_clear", 32'(obs()), 0);
    repeat (2) step();
    check("t6_reset_hold", 32'(obs()), 0);
    tbr = 1'b1;
    rst = 1'b1;
    step();
    check("t6_first_grant", 32'(obs()), 32'({4'b0000, 2'b01, 8'h00}));
    step();
    check("t6_first_write", 32'(obs()), 32'({4'b1100, 2'b01, 8'h61}));
    req0 = 1'b0;
    repeat (10) step();

    // Randomized phase: queued packets per requester, random writer busy
    // time and requester pauses that stay well inside the gap limit.
    begin
      int   busy, dly0, dly1, last_w, owner, prev_owner, o, np;
      logic in_pkt, have_prev, wait0, wait1, done;
      logic [8:0] hd;

      clear_inputs();
      reset_pulse();
      for (int p = 0; p < 12; p++) begin
        np = int'($urandom_range(1, 3));
        for (int b = 0; b < np; b++) q0.push_back({b == np - 1, 8'($urandom)});
        np = int'($urandom_range(1, 3));
        for (int b = 0; b < np; b++) q1.push_back({b == np - 1, 8'($urandom)});
      end
      busy = 0; dly0 = 0; dly1 = 0; last_w = -100;
      owner = 0; prev_owner = 0;
      in_pkt = 1'b0; have_prev = 1'b0; wait0 = 1'b0; wait1 = 1'b0; done = 1'b0;

      for (int c = 0; c < 5000; c++) begin
        step();
        check("rand_no_abort", 32'(abort), 0);
        wait0 &= req0;
        wait1 &= req1;
        if (write) begin
          o = (grant == 2'b10) ? 1 : 0;
          check("rand_grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 1);
          check("rand_ack", 32'({ack0, ack1}), (o == 1) ? 32'(2'b01) : 32'(2'b10));
          if ((o == 0 && q0.size() == 0) || (o == 1 && q1.size() == 0)) begin
            check("rand_unexpected_write", 32'(o), 32'(99));
          end else begin
            hd = (o == 0) ? q0.pop_front() : q1.pop_front();
            check("rand_data", 32'(data_out), 32'(hd[7:0]));
            if (in_pkt)
              check("rand_atomic", 32'(o), 32'(owner));
            else if (have_prev && o == prev_owner)
              check("rand_round_robin", 32'((o == 0) ? wait1 : wait0), 0);
            check("rand_spacing", 32'((c - last_w) >= 3), 1);
            last_w = c;
            owner  = o;
            in_pkt = !hd[8];
            if (hd[8]) begin
              prev_owner = o;
              have_prev  = 1'b1;
              wait0 = 1'b1;
              wait1 = 1'b1;
            end
            if (o == 0) dly0 = int'(hd[8] ? $urandom_range(0, 4) : $urandom_range(0, 2));
            else        dly1 = int'(hd[8] ? $urandom_range(0, 4) : $urandom_range(0, 2));
          end
          busy = int'($urandom_range(0, 3));
        end else begin
          check("rand_no_ack", 32'({ack0, ack1}), 0);
          if (busy > 0) busy--;
        end
        tbr = (busy == 0);
        if (dly0 > 0) begin
          dly0--;
          req0 = 1'b0;
        end else if (q0.size() > 0) begin
          req0 = 1'b1;
          {last0, data0} = q0[0];
        end else begin
          req0 = 1'b0;
        end
        if (dly1 > 0) begin
          dly1--;
          req1 = 1'b0;
        end else if (q1.size() > 0) begin
          req1 = 1'b1;
          {last1, data1} = q1[0];
        end else begin
          req1 = 1'b0;
        end
        if (q0.size() == 0 && q1.size() == 0 && !in_pkt && grant == 2'b00) begin
          done = 1'b1;
          break;
        end
      end
      check("rand_all_bytes_written", 32'(done), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
